// File: rtl/ddr_resp_model_if.sv
// Gowin DDR user-side command/data bundle shared by dram_arb (master)
// and the ddr_resp_model responder (slave).
interface ddr_resp_model_if;
  logic         ddr_calib_done;
  logic [2:0]   ddr_cmd;
  logic         ddr_cmd_en;
  logic [27:0]  ddr_addr;
  logic [127:0] ddr_wr_data;
  logic [15:0]  ddr_wr_data_mask;
  logic         ddr_wr_data_en;
  logic         ddr_cmd_ready;
  logic [127:0] ddr_rd_data;
  logic         ddr_rd_data_valid;
  logic         err;

  // Requester side: issues commands and write data, consumes read returns.
  modport master (
    input  ddr_calib_done, ddr_cmd_ready, ddr_rd_data, ddr_rd_data_valid, err,
    output ddr_cmd, ddr_cmd_en, ddr_addr, ddr_wr_data, ddr_wr_data_mask, ddr_wr_data_en
  );

  // Responder side: the memory model.
  modport slave (
    input  ddr_cmd, ddr_cmd_en, ddr_addr, ddr_wr_data, ddr_wr_data_mask, ddr_wr_data_en,
    output ddr_calib_done, ddr_cmd_ready, ddr_rd_data, ddr_rd_data_valid, err
  );
endinterface

// File: rtl/ddr_resp_model.sv
// ddr_resp_model: synthesizable stand-in for the Gowin DDR controller plus DRAM.
// Models the calibration delay, periodic backpressure, a bounded number of
// in-flight reads returned in order after a fixed latency, and byte-masked
// writes into a 2^ADDR_LG x 128-bit backing store.
module ddr_resp_model #(
  parameter int ADDR_LG      = 10,
  parameter int RD_LAT       = 8,
  parameter int MAX_OUT      = 6,
  parameter int CALIB_CYCLES = 64,
  parameter int BP_PERIOD    = 0
) (
  input  logic            clk,
  input  logic            rst,
  ddr_resp_model_if.slave ddr
);

  localparam int DEPTH = 1 << ADDR_LG;
  localparam int CW    = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int IW    = $clog2(MAX_OUT + 1);
  localparam int BW    = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;

  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
  localparam logic [IW-1:0] MAX_OUT_V  = IW'(MAX_OUT);
  localparam logic [BW-1:0] BP_LAST    = (BP_PERIOD > 0) ? BW'(BP_PERIOD - 1) : '0;
  localparam logic [2:0]    CMD_WR     = 3'b000;
  localparam logic [2:0]    CMD_RD     = 3'b001;

  // Byte-masked merge: mask bit i set keeps the old byte i.
  function automatic logic [127:0] merge_bytes(
    input logic [127:0] old_v,
    input logic [127:0] new_v,
    input logic [15:0]  mask_v
  );
    logic [127:0] res;
    res = old_v;
    for (int i = 0; i < 16; i++) begin
      res[8*i +: 8] = mask_v[i] ? old_v[8*i +: 8] : new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic                     calib_q, calib_d;
  logic [CW-1:0]            calib_cnt_q, calib_cnt_d;
  logic [BW-1:0]            bp_cnt_q, bp_cnt_d;
  logic                     bp_slot_d;
  logic [IW-1:0]            inflight_q, inflight_d;
  logic                     ready_q, ready_d;
  logic                     err_q, err_d;
  logic [RD_LAT-1:0]        vld_q, vld_d;
  logic [RD_LAT-1:0][127:0] dat_q, dat_d;

  logic                     accept_s;
  logic                     rd_acc_s;
  logic                     wr_acc_s;
  logic                     bad_acc_s;
  logic                     ret_s;
  logic [ADDR_LG-1:0]       idx_s;
  logic [127:0]             rd_word_s;
  logic                     unused_addr_s;

  logic [127:0]             mem_q [DEPTH];

  // Byte offset and aliased upper address bits do not select storage.
  assign idx_s         = ddr.ddr_addr[ADDR_LG+3:4];
  assign unused_addr_s = ^{ddr.ddr_addr[27:ADDR_LG+4], ddr.ddr_addr[3:0]};
  assign rd_word_s     = mem_q[idx_s];
  assign accept_s      = ddr.ddr_cmd_en & ready_q;
  assign ret_s         = vld_q[RD_LAT-1];

  // Classify the accepted command; unaccepted cycles have no effect at all.
  always_comb begin
    rd_acc_s  = 1'b0;
    wr_acc_s  = 1'b0;
    bad_acc_s = 1'b0;
    if (accept_s) begin
      case (ddr.ddr_cmd)
        CMD_RD: rd_acc_s = 1'b1;
        CMD_WR: begin
          if (ddr.ddr_wr_data_en) begin
            wr_acc_s = 1'b1;
          end else begin
            bad_acc_s = 1'b1;
          end
        end
        default: bad_acc_s = 1'b1;
      endcase
    end else begin
      rd_acc_s = 1'b0;
    end
  end

  // Calibration counter: calib_done rises on the CALIB_CYCLES-th edge after reset release.
  always_comb begin
    calib_cnt_d = calib_cnt_q;
    calib_d     = calib_q;
    if (calib_q) begin
      calib_cnt_d = calib_cnt_q;
      calib_d     = 1'b1;
    end else begin
      calib_cnt_d = calib_cnt_q + CW'(1);
      calib_d     = (calib_cnt_q == CALIB_LAST);
    end
  end

  // Backpressure phase counter, zero in the first calibrated cycle.
  always_comb begin
    bp_cnt_d = '0;
    if ((BP_PERIOD == 0) || !calib_q) begin
      bp_cnt_d = '0;
    end else if (bp_cnt_q == BP_LAST) begin
      bp_cnt_d = '0;
    end else begin
      bp_cnt_d = bp_cnt_q + BW'(1);
    end
    bp_slot_d = (BP_PERIOD > 0) && calib_d && (bp_cnt_d == BP_LAST);
  end

  // Occupancy, ready and sticky error for the next cycle; ready is computed
  // from next-state values so the registered output is exact in every cycle.
  always_comb begin
    inflight_d = inflight_q + IW'(rd_acc_s) - IW'(ret_s);
    ready_d    = calib_d & (inflight_d < MAX_OUT_V) & ~bp_slot_d;
    err_d      = err_q | bad_acc_s;
  end

  // Read return pipeline; data lanes are zero whenever their valid bit is low.
  always_comb begin
    vld_d = {vld_q[RD_LAT-2:0], rd_acc_s};
    dat_d = {dat_q[RD_LAT-2:0], (rd_acc_s ? rd_word_s : 128'h0)};
  end

  // Control and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calib_q     <= 1'b0;
      calib_cnt_q <= '0;
      bp_cnt_q    <= '0;
      inflight_q  <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= '0;
      dat_q       <= '0;
    end else begin
      calib_q     <= calib_d;
      calib_cnt_q <= calib_cnt_d;
      bp_cnt_q    <= bp_cnt_d;
      inflight_q  <= inflight_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
    end
  end

  // Backing store: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[idx_s] <= merge_bytes(mem_q[idx_s], ddr.ddr_wr_data, ddr.ddr_wr_data_mask);
    end
  end

  assign ddr.ddr_calib_done    = calib_q;
  assign ddr.ddr_cmd_ready     = ready_q;
  assign ddr.ddr_rd_data       = dat_q[RD_LAT-1];
  assign ddr.ddr_rd_data_valid = vld_q[RD_LAT-1];
  assign ddr.err               = err_q;

endmodule

// File: tb/tb_ddr_resp_model.sv
// Testbench for ddr_resp_model: random and directed traffic checked every
// cycle against a transaction-level model (word array + queue of pending
// returns with their due cycle). A second instance with BP_PERIOD=4 sits idle
// so its ready pattern can be checked.
module tb_ddr_resp_model;
  localparam int ADDR_LG = 10;
  localparam int RD_LAT  = 8;
  localparam int MAX_OUT = 6;
  localparam int CALIB   = 64;
  localparam int BP      = 4;
  localparam logic [2:0] RD  = 3'b001;
  localparam logic [2:0] WR  = 3'b000;
  localparam logic [2:0] ILL = 3'b111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_resp_model_if bus_a ();
  ddr_resp_model_if bus_b ();

  ddr_resp_model #(.ADDR_LG(ADDR_LG), .RD_LAT(RD_LAT), .MAX_OUT(MAX_OUT),
                   .CALIB_CYCLES(CALIB), .BP_PERIOD(0))
    u_dut_a (.clk(clk), .rst(rst), .ddr(bus_a.slave));

  ddr_resp_model #(.ADDR_LG(ADDR_LG), .RD_LAT(RD_LAT), .MAX_OUT(MAX_OUT),
                   .CALIB_CYCLES(CALIB), .BP_PERIOD(BP))
    u_dut_b (.clk(clk), .rst(rst), .ddr(bus_b.slave));

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    logic [127:0] data;
  } rd_t;

  logic [127:0] mem_m [1 << ADDR_LG];
  rd_t          pend_q[$];
  int           t;       // current cycle number
  int           rel;     // clock edges since reset release
  bit           err_m;
  int           n_tests;
  int           n_fail;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, t, got, exp);
    end
  endtask

  function automatic bit exp_calib();
    return (rst === 1'b0) && (rel >= CALIB);
  endfunction

  function automatic bit exp_bp_slot(input int period);
    return (period > 0) && exp_calib() && (((rel - CALIB) % period) == period - 1);
  endfunction

  function automatic bit exp_ready_a();
    return exp_calib() && (pend_q.size() < MAX_OUT);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_outputs();
    bit           ev;
    logic [127:0] ed;
    ev = (pend_q.size() > 0) && (pend_q[0].due == t);
    ed = ev ? pend_q[0].data : 128'h0;
    chk("a_calib", bus_a.ddr_calib_done, exp_calib());
    chk("a_ready", bus_a.ddr_cmd_ready, exp_ready_a());
    chk("a_valid", bus_a.ddr_rd_data_valid, ev);
    chk("a_rd_data", bus_a.ddr_rd_data, ed);
    chk("a_err", bus_a.err, err_m);
    chk("b_calib", bus_b.ddr_calib_done, exp_calib());
    chk("b_ready", bus_b.ddr_cmd_ready, exp_calib() && !exp_bp_slot(BP));
    chk("b_valid", bus_b.ddr_rd_data_valid, 1'b0);
    chk("b_err", bus_b.err, 1'b0);
  endtask

  // One clock: apply the spec rules to the inputs present before the edge,
  // then compare all outputs shortly after the edge.
  task automatic step();
    bit acc;
    int idx;
    acc = (rst === 1'b0) && (bus_a.ddr_cmd_en === 1'b1) && exp_ready_a();
    idx = int'(bus_a.ddr_addr[ADDR_LG+3:4]);
    @(posedge clk);
    if (rst === 1'b0) begin
      if ((pend_q.size() > 0) && (pend_q[0].due == t)) void'(pend_q.pop_front());
      if (acc) begin
        case (bus_a.ddr_cmd)
          RD: pend_q.push_back('{due: t + RD_LAT, data: mem_m[idx]});
          WR: begin
            if (bus_a.ddr_wr_data_en) begin
              for (int b = 0; b < 16; b++)
                if (!bus_a.ddr_wr_data_mask[b]) mem_m[idx][8*b +: 8] = bus_a.ddr_wr_data[8*b +: 8];
            end else begin
              err_m = 1'b1;
            end
          end
          default: err_m = 1'b1;
        endcase
      end
      rel++;
    end
    t++;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic en, input logic [2:0] cmd, input int idx,
                       input logic [127:0] d, input logic [15:0] m, input logic den);
    logic [27:0] a;
    a = 28'($urandom());
    a[ADDR_LG+3:4] = ADDR_LG'(idx);
    bus_a.ddr_cmd_en       = en;
    bus_a.ddr_cmd          = cmd;
    bus_a.ddr_addr         = a;
    bus_a.ddr_wr_data      = d;
    bus_a.ddr_wr_data_mask = m;
    bus_a.ddr_wr_data_en   = den;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, RD, 0, 128'h0, 16'h0, 1'b0);
      step();
    end
  endtask

  // Steps with idle inputs until a read return appears; lat counts edges
  // after the current cycle. Bounded so a missing return is reported.
  task automatic await_valid(output int lat, output logic [127:0] d);
    lat = 0;
    do begin
      drive(1'b0, RD, 0, 128'h0, 16'h0, 1'b0);
      step();
      lat++;
    end while ((bus_a.ddr_rd_data_valid !== 1'b1) && (lat < 40));
    if (bus_a.ddr_rd_data_valid !== 1'b1) chk("await_timeout", bus_a.ddr_rd_data_valid, 1'b1);
    d = bus_a.ddr_rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           n_open;
    int           seen_valid;
    bit           stall_seen;
    bit           reopened;
    int           r;
    logic [127:0] d;
    logic [127:0] pat;

    n_tests = 0; n_fail = 0; t = 0; rel = 0; err_m = 1'b0;
    for (int i = 0; i < (1 << ADDR_LG); i++) mem_m[i] = 128'h0;
    bus_b.ddr_cmd_en = 1'b0; bus_b.ddr_cmd = RD; bus_b.ddr_addr = 28'h0;
    bus_b.ddr_wr_data = 128'h0; bus_b.ddr_wr_data_mask = 16'h0; bus_b.ddr_wr_data_en = 1'b0;
    rst = 1'b1;
    drive(1'b0, RD, 0, 128'h0, 16'h0, 1'b0);
    step(); step();

    // Test 1: cmd_en held high with an illegal code through calibration;
    // nothing may be accepted (err stays 0) until ready rises on edge 64.
    drive(1'b1, ILL, 3, rand128(), 16'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < CALIB; i++) step();
    chk("t1_calib_done_at_64", bus_a.ddr_calib_done, 1'b1);
    chk("t1_no_accept_before_calib", bus_a.err, 1'b0);

    // Prefill a 16-word window with random data.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, WR, i, rand128(), 16'h0, 1'b1);
      step();
    end

    // Test 2: pattern write then read, valid exactly RD_LAT cycles after accept.
    pat = 128'h0F0E0D0C0B0A09080706050403020100;
    drive(1'b1, WR, 4, pat, 16'h0, 1'b1); step();
    drive(1'b1, RD, 4, 128'h0, 16'h0, 1'b0); step();
    await_valid(lat, d);
    chk("t2_latency", lat + 1, RD_LAT);
    chk("t2_data", d, pat);

    // Test 3: masked write keeps the masked (low) bytes.
    drive(1'b1, WR, 7, {16{8'hFF}}, 16'h0, 1'b1); step();
    drive(1'b1, WR, 7, 128'h0, 16'h00FF, 1'b1); step();
    drive(1'b1, RD, 7, 128'h0, 16'h0, 1'b0); step();
    await_valid(lat, d);
    chk("t3_masked", d, {64'h0, {8{8'hFF}}});

    // Test 4: read sees pre-write contents; a later read sees the new value.
    drive(1'b1, RD, 4, 128'h0, 16'h0, 1'b0); step();
    drive(1'b1, WR, 4, {16{8'h55}}, 16'h0, 1'b1); step();
    drive(1'b1, RD, 4, 128'h0, 16'h0, 1'b1); step();
    await_valid(lat, d);
    chk("t4_old_value", d, pat);
    await_valid(lat, d);
    chk("t4_new_value", d, {16{8'h55}});
    idle(10);

    // Test 5: reads every cycle; ready drops after MAX_OUT accepts and reopens.
    stall_seen = 1'b0; reopened = 1'b0; n_open = 0;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, RD, $urandom_range(0, 15), 128'h0, 16'h0, 1'b0);
      if (!stall_seen) begin
        if (bus_a.ddr_cmd_ready) n_open++;
        else stall_seen = 1'b1;
      end else if (bus_a.ddr_cmd_ready) begin
        reopened = 1'b1;
      end
      step();
    end
    chk("t5_accepts_before_stall", n_open, MAX_OUT);
    chk("t5_reopen", reopened, 1'b1);
    idle(12);

    // Random legal traffic, including stray wr_data_en on reads and idles.
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      drive(1'b1, RD, $urandom_range(0, 15), rand128(), 16'($urandom()), 1'($urandom()));
      else if (r < 80) drive(1'b1, WR, $urandom_range(0, 15), rand128(), 16'($urandom()), 1'b1);
      else             drive(1'b0, WR, $urandom_range(0, 15), rand128(), 16'h0, 1'($urandom()));
      step();
    end
    idle(12);

    // Test 6a: write without data enable sets err, storage unchanged.
    drive(1'b1, WR, 3, rand128(), 16'h0, 1'b0); step();
    chk("t6_err_wr_no_data", bus_a.err, 1'b1);
    drive(1'b1, RD, 3, 128'h0, 16'h0, 1'b0); step();
    await_valid(lat, d);
    chk("t6_wr_no_data_unchanged", d, mem_m[3]);

    // Test 6b: async reset with reads in flight.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, RD, c, 128'h0, 16'h0, 1'b0);
      step();
    end
    drive(1'b0, RD, 0, 128'h0, 16'h0, 1'b0);
    rst = 1'b1;
    pend_q.delete(); err_m = 1'b0; rel = 0;
    #1;
    chk("t6_rst_async_valid", bus_a.ddr_rd_data_valid, 1'b0);
    chk("t6_rst_async_err", bus_a.err, 1'b0);
    chk("t6_rst_async_ready", bus_a.ddr_cmd_ready, 1'b0);
    chk("t6_rst_async_data", bus_a.ddr_rd_data, 128'h0);
    step(); step();
    rst = 1'b0;
    seen_valid = 0;
    for (int c = 0; c < CALIB + RD_LAT + 4; c++) begin
      step();
      if (bus_a.ddr_rd_data_valid === 1'b1) seen_valid++;
    end
    chk("t6_no_valid_after_rst", seen_valid, 0);

    // Test 6c: illegal command sets err; storage survived reset.
    drive(1'b1, ILL, 2, rand128(), 16'h0, 1'b1); step();
    chk("t6_err_illegal", bus_a.err, 1'b1);
    drive(1'b1, RD, 2, 128'h0, 16'h0, 1'b0); step();
    await_valid(lat, d);
    chk("t6_storage_kept", d, mem_m[2]);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
